// File: rtl/cw305_axil_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cw305_axil_pkg                                                             |
// | Register map, CTRL/STATUS bit positions and shared types for the mailbox.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cw305_axil_pkg;

  typedef logic [127:0] word128_t;

  localparam logic [7:0] C_OFF_CTRL    = 8'h00;
  localparam logic [7:0] C_OFF_STATUS  = 8'h04;
  localparam logic [7:0] C_OFF_KEY0    = 8'h10;
  localparam logic [7:0] C_OFF_TEXT0   = 8'h20;
  localparam logic [7:0] C_OFF_CIPHER0 = 8'h30;

  localparam int C_CTRL_DONE      = 0;
  localparam int C_CTRL_IE        = 1;
  localparam int C_STATUS_PENDING = 0;
  localparam int C_STATUS_OVERRUN = 1;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cw305_axil_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cw305_axil_if                                                              |
// | AXI4-Lite slave handshakes: independent AW/W latching, one write in flight,|
// | registered single-beat read response.                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cw305_axil_if (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [31:0] i_awaddr,
  input  logic        i_wvalid,
  output logic        o_wready,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_bvalid,
  input  logic        i_bready,
  input  logic        i_arvalid,
  output logic        o_arready,
  input  logic [31:0] i_araddr,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [31:0] o_rdata,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_strb,
  output logic [31:0] o_rd_addr,
  input  logic [31:0] i_rd_data
);

  logic        r_aw_full;
  logic        r_w_full;
  logic        r_bvalid;
  logic        r_rvalid;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_ar_fire;

  assign o_awready = !reset && !r_aw_full && !r_bvalid;
  assign o_wready  = !reset && !r_w_full && !r_bvalid;
  assign o_arready = !reset && !r_rvalid;
  assign w_aw_fire = i_awvalid && o_awready;
  assign w_w_fire  = i_wvalid && o_wready;
  assign w_ar_fire = i_arvalid && o_arready;

  // Both halves latched: the register file commits on this edge and B rises with it.
  assign o_wr_en   = r_aw_full && r_w_full;
  assign o_wr_addr = r_awaddr;
  assign o_wr_data = r_wdata;
  assign o_wr_strb = r_wstrb;
  assign o_rd_addr = i_araddr;
  assign o_bvalid  = r_bvalid;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_aw_fire) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= i_awaddr;
      end else if (o_wr_en) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_fire) begin
        r_w_full <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end else if (o_wr_en) begin
        r_w_full <= 1'b0;
      end
      if (o_wr_en)       r_bvalid <= 1'b1;
      else if (i_bready) r_bvalid <= 1'b0;
      if (w_ar_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= i_rd_data;
      end else if (i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cw305_axil_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cw305_axil_mailbox                                                         |
// | AXI4-Lite mailbox between the core and the CW305 register block.           |
// | Option macro: CW305_AXIL_IRQ_EN enables CTRL.IE and irq_out.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cw305_axil_mailbox import cw305_axil_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_axi_awvalid,
  output logic         mem_axi_awready,
  input  logic [31:0]  mem_axi_awaddr,
  input  logic [2:0]   mem_axi_awprot,
  input  logic         mem_axi_wvalid,
  output logic         mem_axi_wready,
  input  logic [31:0]  mem_axi_wdata,
  input  logic [3:0]   mem_axi_wstrb,
  output logic         mem_axi_bvalid,
  input  logic         mem_axi_bready,
  input  logic         mem_axi_arvalid,
  output logic         mem_axi_arready,
  input  logic [31:0]  mem_axi_araddr,
  input  logic [2:0]   mem_axi_arprot,
  output logic         mem_axi_rvalid,
  input  logic         mem_axi_rready,
  output logic [31:0]  mem_axi_rdata,
  input  logic         cw_start,
  input  logic [127:0] cw_key,
  input  logic [127:0] cw_text,
  output logic [127:0] cw_cipher,
  output logic         cw_busy,
  output logic         irq_out
);

  logic        w_wr_en;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [31:0] w_rd_addr;
  logic [31:0] w_rd_data;
  logic        w_wr_hit;
  logic        w_rd_hit;
  logic [5:0]  w_wr_word;
  logic [5:0]  w_rd_word;
  logic        w_ctrl_wr;
  logic        w_done;
  logic        w_ovr_clr;
  logic        w_accept;
  logic        w_ie;
  logic        w_unused;
  word128_t    r_key;
  word128_t    r_text;
  word128_t    r_cipher;
  logic        r_pending;
  logic        r_overrun;

  cw305_axil_if u_if (
    .clk       (clk),
    .reset     (reset),
    .i_awvalid (mem_axi_awvalid),
    .o_awready (mem_axi_awready),
    .i_awaddr  (mem_axi_awaddr),
    .i_wvalid  (mem_axi_wvalid),
    .o_wready  (mem_axi_wready),
    .i_wdata   (mem_axi_wdata),
    .i_wstrb   (mem_axi_wstrb),
    .o_bvalid  (mem_axi_bvalid),
    .i_bready  (mem_axi_bready),
    .i_arvalid (mem_axi_arvalid),
    .o_arready (mem_axi_arready),
    .i_araddr  (mem_axi_araddr),
    .o_rvalid  (mem_axi_rvalid),
    .i_rready  (mem_axi_rready),
    .o_rdata   (mem_axi_rdata),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data)
  );

  assign w_unused  = &{1'b0, mem_axi_awprot, mem_axi_arprot, w_wr_addr[1:0], w_rd_addr[1:0]};
  assign w_wr_hit  = w_wr_en && (w_wr_addr[31:8] == BASE_ADDR[31:8]);
  assign w_rd_hit  = (w_rd_addr[31:8] == BASE_ADDR[31:8]);
  assign w_wr_word = w_wr_addr[7:2];
  assign w_rd_word = w_rd_addr[7:2];
  assign w_ctrl_wr = w_wr_hit && (w_wr_word == C_OFF_CTRL[7:2]) && w_wr_strb[0];
  assign w_ovr_clr = w_wr_hit && (w_wr_word == C_OFF_STATUS[7:2]) && w_wr_strb[0]
                     && w_wr_data[C_STATUS_OVERRUN];
  assign w_done    = w_ctrl_wr && w_wr_data[C_CTRL_DONE] && r_pending;
  // A DONE landing with a start frees the slot in time, so the new job is taken cleanly.
  assign w_accept  = cw_start && (!r_pending || w_done);

  assign cw_cipher = r_cipher;
  assign cw_busy   = r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key     <= '0;
      r_text    <= '0;
      r_cipher  <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_hit && (w_wr_word[5:2] == C_OFF_CIPHER0[7:4])) begin
        r_cipher[{w_wr_word[1:0], 5'b0} +: 32] <=
          strb_merge(r_cipher[{w_wr_word[1:0], 5'b0} +: 32], w_wr_data, w_wr_strb);
      end
      if (w_accept) begin
        r_key     <= cw_key;
        r_text    <= cw_text;
        r_pending <= 1'b1;
      end else if (w_done) begin
        r_pending <= 1'b0;
      end
      if (cw_start && !w_accept) r_overrun <= 1'b1;
      else if (w_ovr_clr)        r_overrun <= 1'b0;
    end
  end

`ifdef CW305_AXIL_IRQ_EN
  logic r_ie;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= w_wr_data[C_CTRL_IE];
      r_irq <= r_pending && r_ie;
    end
  end

  assign w_ie    = r_ie;
  assign irq_out = r_irq;
`else
  assign w_ie    = 1'b0;
  assign irq_out = 1'b0;
`endif

  // Read data is taken from current state, so a same-edge write is not visible.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_hit) begin
      if (w_rd_word == C_OFF_CTRL[7:2]) begin
        w_rd_data[C_CTRL_IE] = w_ie;
      end else if (w_rd_word == C_OFF_STATUS[7:2]) begin
        w_rd_data[C_STATUS_PENDING] = r_pending;
        w_rd_data[C_STATUS_OVERRUN] = r_overrun;
      end else if (w_rd_word[5:2] == C_OFF_KEY0[7:4]) begin
        w_rd_data = r_key[{w_rd_word[1:0], 5'b0} +: 32];
      end else if (w_rd_word[5:2] == C_OFF_TEXT0[7:4]) begin
        w_rd_data = r_text[{w_rd_word[1:0], 5'b0} +: 32];
      end else if (w_rd_word[5:2] == C_OFF_CIPHER0[7:4]) begin
        w_rd_data = r_cipher[{w_rd_word[1:0], 5'b0} +: 32];
      end
    end
  end

endmodule
`default_nettype wire
